// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the asynchronous FIFO: write-pointer synchronizer, read pointer,
// empty flag, occupancy level and a one-entry valid/ready output register.
module fifo_read_ctrl #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr_gray,
  input  logic [DATASIZE-1:0] rdata_mem,
  input  logic                rready,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic                rempty,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int unsigned PtrW = ADDRSIZE + 1;

  logic [PtrW-1:0] rq1_wptr;
  logic [PtrW-1:0] rq2_wptr;
  logic [PtrW-1:0] rbin;
  logic [PtrW-1:0] rbinnext;
  logic [PtrW-1:0] rgraynext;
  logic [PtrW-1:0] wbin_sync;
  logic            pop;

  // Two-flop synchronizer; nothing else may look at wptr_gray.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq1_wptr <= '0;
      rq2_wptr <= '0;
    end else begin
      rq1_wptr <= wptr_gray;
      rq2_wptr <= rq1_wptr;
    end
  end

  assign pop       = !rempty && (!rvalid || rready);
  assign rbinnext  = rbin + PtrW'(pop);
  assign rgraynext = rbinnext ^ (rbinnext >> 1);
  assign raddr     = rbin[ADDRSIZE-1:0];

  // Empty compares against the pre-update rq2_wptr, so a write landing this cycle errs to empty.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      rempty    <= 1'b1;
    end else begin
      rbin      <= rbinnext;
      rptr_gray <= rgraynext;
      rempty    <= (rgraynext == rq2_wptr);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (pop) begin
      rdata  <= rdata_mem;
      rvalid <= 1'b1;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  always_comb begin
    wbin_sync = '0;
    for (int i = 0; i < int'(PtrW); i++) begin
      wbin_sync[i] = ^(rq2_wptr >> i);
    end
  end

  assign rlevel = wbin_sync - rbin;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: a written-order queue plus a pointer-count model
// predicts every output at each falling edge.
module tb_fifo_read_ctrl;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b1;
  logic [4:0] wptr_gray = '0;
  logic [7:0] rdata_mem;
  logic       rready = 1'b0;
  logic [3:0] raddr;
  logic [4:0] rptr_gray;
  logic       rempty;
  logic [7:0] rdata;
  logic       rvalid;
  logic [4:0] rlevel;

  logic [7:0] mem [16];
  assign rdata_mem = mem[raddr];

  fifo_read_ctrl #(.DATASIZE(8), .ADDRSIZE(4)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .wptr_gray (wptr_gray),
    .rdata_mem (rdata_mem),
    .rready    (rready),
    .raddr     (raddr),
    .rptr_gray (rptr_gray),
    .rempty    (rempty),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rlevel    (rlevel)
  );

  always #5 rclk = ~rclk;

  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned wbin;
  int unsigned m_rd;
  int unsigned s1;
  int unsigned s2;
  int unsigned m_xfers;
  bit          m_empty;
  bit          m_valid;
  logic [7:0]  m_data;
  logic [7:0]  q[$];
  logic [4:0]  prev_gray;

  function automatic logic [4:0] gray(input int unsigned v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rempty"}, 32'(rempty), 32'd1);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_raddr"}, 32'(raddr), 32'd0);
    check({tag, "_rptr_gray"}, 32'(rptr_gray), 32'd0);
    check({tag, "_rlevel"}, 32'(rlevel), 32'd0);
  endtask

  // Called just after a falling edge; reset lands mid-cycle, away from any rclk edge.
  task automatic do_reset(input int unsigned w);
    #2;
    rrst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    rready    = 1'b0;
    wbin      = w;
    wptr_gray = gray(w);
    q.delete();
    for (int i = 0; i < int'(w); i++) q.push_back(mem[i]);
    m_rd = 0; s1 = 0; s2 = 0; m_xfers = 0;
    m_empty = 1'b1; m_valid = 1'b0; m_data = '0; prev_gray = '0;
    @(posedge rclk);
    @(negedge rclk);
    check_reset_outputs("held_rst");
    rrst_n = 1'b1;
  endtask

  task automatic try_write(input logic [7:0] d, output bit ok);
    ok = (((wbin - m_rd) & 31) < 16);
    if (ok) begin
      mem[wbin % 16] = d;
      q.push_back(d);
      wbin      = (wbin + 1) & 31;
      wptr_gray = gray(wbin);
    end
  endtask

  // One rclk cycle: predict next state from current inputs, then compare at the falling edge.
  task automatic step();
    bit          pop;
    bit          xfer;
    int unsigned rd_n;
    bit          empty_n;
    bit          valid_n;
    logic [7:0]  data_n;
    pop     = !m_empty && (!m_valid || rready);
    xfer    = m_valid && rready;
    rd_n    = (m_rd + 32'(pop)) & 31;
    empty_n = (rd_n == s2);
    valid_n = pop ? 1'b1 : (xfer ? 1'b0 : m_valid);
    data_n  = m_data;
    if (pop) data_n = (q.size() > 0) ? q.pop_front() : 8'hxx;
    @(posedge rclk);
    m_rd = rd_n; m_empty = empty_n; m_valid = valid_n; m_data = data_n;
    s2 = s1; s1 = wbin;
    if (xfer) m_xfers++;
    @(negedge rclk);
    check("rempty", 32'(rempty), 32'(m_empty));
    check("rvalid", 32'(rvalid), 32'(m_valid));
    check("rdata", 32'(rdata), 32'(m_data));
    check("raddr", 32'(raddr), m_rd % 16);
    check("rptr_gray", 32'(rptr_gray), 32'(gray(m_rd)));
    check("rlevel", 32'(rlevel), (s2 - m_rd) & 31);
    check("gray_one_bit", 32'($countones(rptr_gray ^ prev_gray)), 32'(pop));
    check("rlevel_max", 32'(rlevel <= 5'd16), 32'd1);
    prev_gray = rptr_gray;
  endtask

  // mode 0: rready 1,0,0,1 pattern; 1: random; 2: always ready.
  task automatic run(input int nwords, input int mode);
    int cyc = 0;
    int written = 0;
    bit ok;
    while ((written < nwords || !m_empty || m_valid || s2 != wbin) && cyc < 3000) begin
      case (mode)
        0:       rready = (cyc % 4 == 0) || (cyc % 4 == 3);
        1:       rready = 1'($urandom_range(0, 1));
        default: rready = 1'b1;
      endcase
      if (written < nwords && (mode == 0 || $urandom_range(0, 2) != 0)) begin
        try_write(8'($urandom), ok);
        if (ok) written++;
      end
      step();
      cyc++;
    end
    check("run_completes", 32'(cyc < 3000), 32'd1);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    @(negedge rclk);

    // Reset, then a single word with rready low.
    do_reset(0);
    try_write(8'hA5, ok);
    step();
    check("sw_e0_rempty", 32'(rempty), 32'd1);
    step();
    check("sw_e1_rlevel", 32'(rlevel), 32'd1);
    check("sw_e1_rempty", 32'(rempty), 32'd1);
    step();
    check("sw_e2_rempty", 32'(rempty), 32'd0);
    step();
    check("sw_e3_rvalid", 32'(rvalid), 32'd1);
    check("sw_e3_rdata", 32'(rdata), 32'hA5);
    check("sw_e3_rempty", 32'(rempty), 32'd1);
    step();
    step();
    check("sw_hold_rvalid", 32'(rvalid), 32'd1);
    rready = 1'b1;
    step();
    check("sw_drop_rvalid", 32'(rvalid), 32'd0);

    // Reset held with write pointer Gray(2).
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    do_reset(2);
    step();
    step();
    check("rst_level_two", 32'(rlevel), 32'd2);
    run(0, 2);

    // Full memory drained at one word per cycle.
    do_reset(0);
    for (int i = 0; i < 16; i++) try_write(8'(i) ^ 8'h3C, ok);
    check("drain_wptr", 32'(wptr_gray), 32'h18);
    rready = 1'b1;
    step();
    step();
    check("drain_full_level", 32'(rlevel), 32'd16);
    check("drain_full_rempty", 32'(rempty), 32'd1);
    step();
    check("drain_full_rempty_fall", 32'(rempty), 32'd0);
    for (int i = 0; i < 17; i++) step();
    check("drain_xfers", m_xfers, 32'd16);
    check("drain_final_gray", 32'(rptr_gray), 32'h18);
    check("drain_final_rempty", 32'(rempty), 32'd1);

    // Backpressure, then a random stream across the pointer wrap.
    run(4, 0);
    run(40, 1);

    // Mid-stream reset after three transfers, then resume from zero.
    do_reset(0);
    for (int i = 0; i < 8; i++) try_write(8'(8'h80 + i), ok);
    rready = 1'b1;
    for (int c = 0; c < 40 && m_xfers < 3; c++) step();
    check("mid_three_xfers", m_xfers, 32'd3);
    do_reset(0);
    run(10, 1);
    run(6, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the team's asynchronous FIFO. It brings the write-domain Gray write pointer into the read clock domain and generates the read address and read Gray pointer for the shared dual-port memory. It also produces the empty flag and an occupancy count. Entries popped from the memory are presented to the consumer through a one-entry registered output stage with a valid/ready handshake. It pairs with the write-side memory/pointer logic and returns `rptr_gray` to the write domain for full detection.

## Interface
- `DATASIZE`, default 8: data word width.
- `ADDRSIZE`, default 4: memory address width; depth = 2^ADDRSIZE.

Ports (clock and reset first):
- `rclk` in, 1: read-domain clock; all state updates on its rising edge.
- `rrst_n` in, 1: reset, asynchronous, active-low.
- `wptr_gray` in, ADDRSIZE+1: write pointer, Gray-coded, from the write domain. It is asynchronous to `rclk`.
- `rdata_mem` in, DATASIZE: combinational memory read data at `raddr`.
- `rready` in, 1: consumer accepts `rdata` this cycle.
- `raddr` out, ADDRSIZE: memory read address, equal to `rbin[ADDRSIZE-1:0]`.
- `rptr_gray` out, ADDRSIZE+1: registered Gray read pointer, sent to the write domain.
- `rempty` out, 1: memory holds no unread entry (excludes the output register).
- `rdata` out, DATASIZE: registered output data.
- `rvalid` out, 1: `rdata` holds a valid word.
- `rlevel` out, ADDRSIZE+1: count of unread memory entries, range 0..2^ADDRSIZE.

## Operation
**Synchronizer**
- `wptr_gray` passes through two flops, `rq1_wptr` then `rq2_wptr`.
- No other logic samples `wptr_gray`.

**Read pointer**
- `rbin` is an (ADDRSIZE+1)-bit binary counter.
- `rptr_gray = rbin ^ (rbin >> 1)`, registered.
- `pop = !rempty && (!rvalid || rready)`.
- On pop: `rbinnext = rbin + 1`, wrapping modulo 2^(ADDRSIZE+1); `rgraynext` is the Gray encoding of `rbinnext`.

**Empty flag**
- `rempty` is registered: `rempty <= (rgraynext == rq2_wptr)`, compared across all ADDRSIZE+1 bits.

**Output stage**
- On pop: `rdata <= rdata_mem` and `rvalid <= 1`.
- If `rvalid && rready` and no pop: `rvalid <= 0`, and `rdata` holds its last value.
- While `rvalid && !rready`: `rdata` and `rvalid` hold.

**Level**
- `rlevel = gray2bin(rq2_wptr) - rbin`, modulo 2^(ADDRSIZE+1). It is combinational from registers.

**Boundary conditions**
- Full memory (`rlevel` = 2^ADDRSIZE): `rempty` = 0 and `rlevel` MSB = 1.
- Simultaneous pop with a new write arriving: `rempty` is evaluated using the pre-update `rq2_wptr`.
  - This errs toward empty (pessimistic) and must never report not-empty falsely.
- Pointer wrap: at 2^(ADDRSIZE+1)-1 → 0 the Gray code changes exactly one bit.
- Reset asserted mid-stream: all state clears immediately.
  - Entries that were in flight are discarded.
  - The write side must be reset concurrently.

## Timing
**Reset values**
- `rbin`, `rptr_gray`, `rq1_wptr`, `rq2_wptr` = 0.
- `rempty` = 1, `rvalid` = 0, `rdata` = 0.
- Hence `raddr` = 0 and `rlevel` = 0.

**Write-to-read latency** (new `wptr_gray` stable before `rclk` edge E, FIFO previously empty, output stage empty)
- Edge E: `rq1_wptr` updates.
- Edge E+1: `rq2_wptr` updates and `rlevel` updates.
- Edge E+2: `rempty` falls.
- Edge E+3: pop; `rvalid` = 1 and `rdata` is valid.

**Throughput and handshake**
- With `rready` held 1 and memory not empty: one pop per cycle, no bubbles.
- A transfer completes on any edge where `rvalid && rready`.
- `rvalid` never drops without a transfer.

## Test plan
- **Reset:** hold `rrst_n`=0 with `wptr_gray` = 5'b00011.
  - Required: `rempty`=1, `rvalid`=0, `rdata`=0, `raddr`=0, `rptr_gray`=0, `rlevel`=0.
  - After release, `rlevel`=2 two edges later.
- **Single word:** `wptr_gray` 0→1 with `rdata_mem`=8'hA5 at `raddr` 0, `rready`=0.
  - Required: `rempty` falls at E+2; `rvalid`=1 and `rdata`=A5 at E+3; `rempty` returns to 1.
  - `rvalid` stays 1 until `rready`=1, then falls after one edge.
- **Full drain:** `wptr_gray` = Gray(16) (5'b11000), memory pattern `addr` ^ 8'h3C, `rready`=1.
  - Required: 16 consecutive transfers with data 3C, 3D, …, 33.
  - `rlevel` decrements 16→0; `rempty`=1 after the last pop; `rptr_gray`=5'b11000.
- **Backpressure:** 4 entries, `rready` toggled 1,0,0,1,….
  - Required: no word lost or duplicated; `rdata` stable while `rvalid && !rready`.
  - `raddr` advances only on pop.
- **Wrap:** stream 40 words with `wptr_gray` stepping in Gray code through 31→0.
  - Required: `rptr_gray` changes exactly 1 bit per pop.
  - Data is in order across the 2^(ADDRSIZE+1) wrap; `rlevel` never exceeds 16.
- **Mid-stream reset:** assert `rrst_n`=0 after 3 of 8 words.
  - Required: outputs reach reset values without waiting for an `rclk` edge.
  - Normal operation resumes after release once the write pointer is reset to 0.
